cle_engine: RTL and testbench

CLE_ENGINE -- requirements
Module: cle_engine

---
 rtl/cle_pkg.sv | 22 ++
 rtl/cle_nbr8.sv | 30 +++
 rtl/cle_engine.sv | 136 +++++++++++++
 tb/tb_cle_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cle_pkg.sv
// Shared constants and state encoding for the connected-component labelling engine.
package cle_pkg;
  localparam int unsigned IMG_W      = 32;
  localparam int unsigned IMG_H      = 32;
  localparam int unsigned NPIX       = IMG_W * IMG_H;
  localparam int unsigned COORD_W    = 5;
  localparam int unsigned ROM_DEPTH  = 128;
  localparam int unsigned ROM_AW     = 7;
  localparam int unsigned SRAM_DEPTH = 1024;
  localparam int unsigned SRAM_AW    = 10;
  localparam int unsigned LABEL_W    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEEK,
    S_GROW,
    S_WRITE,
    S_CLEAR,
    S_DONE
  } state_t;
endpackage

// File: rtl/cle_nbr8.sv
// Border-aware 8-neighbour test: is any neighbour of pixel idx already in the region?
module cle_nbr8
  import cle_pkg::*;
(
  input  logic [NPIX-1:0]    region,
  input  logic [SRAM_AW-1:0] idx,
  output logic               hit
);
  logic [COORD_W-1:0] row, col;
  logic               up, dn, lf, rt;

  assign row = idx[SRAM_AW-1:COORD_W];
  assign col = idx[COORD_W-1:0];

  // Edge guards stop column 31 wrapping onto column 0 of the adjacent row.
  always_comb begin
    up  = (row != '0);
    dn  = (row != '1);
    lf  = (col != '0);
    rt  = (col != '1);
    hit = (up && lf && region[idx - SRAM_AW'(IMG_W + 1)]) ||
          (up &&       region[idx - SRAM_AW'(IMG_W)])     ||
          (up && rt && region[idx - SRAM_AW'(IMG_W - 1)]) ||
          (lf &&       region[idx - SRAM_AW'(1)])         ||
          (rt &&       region[idx + SRAM_AW'(1)])         ||
          (dn && lf && region[idx + SRAM_AW'(IMG_W - 1)]) ||
          (dn &&       region[idx + SRAM_AW'(IMG_W)])     ||
          (dn && rt && region[idx + SRAM_AW'(IMG_W + 1)]);
  end
endmodule

// File: rtl/cle_engine.sv
// Labels 8-connected objects of a 32x32 binary image from ROM into a label SRAM.
module cle_engine
  import cle_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rom_q,
  output logic [ROM_AW-1:0]    rom_a,
  output logic [SRAM_AW-1:0]   sram_a,
  output logic [LABEL_W-1:0]   sram_d,
  output logic                 sram_wen,
  output logic                 finish
);
  state_t               state, state_nx;
  logic [NPIX-1:0]      img, fg, region;
  logic [SRAM_AW-1:0]   idx, seek_idx;
  logic [ROM_AW-1:0]    ld_cnt;
  logic [LABEL_W-1:0]   label;
  logic                 fwd, added;
  logic                 hit, grow_add, idx_last, sweep_end;

  cle_nbr8 u_nbr8 (
    .region (region),
    .idx    (idx),
    .hit    (hit)
  );

  assign grow_add  = img[idx] && !region[idx] && hit;
  assign idx_last  = (idx == '1);
  assign sweep_end = fwd ? idx_last : (idx == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = S_LOAD;
      S_LOAD:  if (ld_cnt == '1) state_nx = S_SEEK;
      S_SEEK: begin
        if (img[seek_idx])          state_nx = S_GROW;
        else if (seek_idx == '1)    state_nx = S_CLEAR;
      end
      S_GROW:  if (sweep_end && !added && !grow_add) state_nx = S_WRITE;
      S_WRITE: if (idx_last) state_nx = S_SEEK;
      S_CLEAR: if (idx_last) state_nx = S_DONE;
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_a    <= '0;
      sram_a   <= '0;
      sram_d   <= '0;
      sram_wen <= 1'b1;
      finish   <= 1'b0;
      img      <= '0;
      fg       <= '0;
      region   <= '0;
      idx      <= '0;
      seek_idx <= '0;
      ld_cnt   <= '0;
      label    <= '0;
      fwd      <= 1'b1;
      added    <= 1'b0;
    end else begin
      sram_wen <= 1'b1;
      case (state)
        S_IDLE: begin
          // ROM samples address 0 at this edge, so the next address goes out now.
          rom_a  <= ROM_AW'(1);
          ld_cnt <= '0;
        end
        S_LOAD: begin
          for (int unsigned j = 0; j < 8; j++) begin
            img[{ld_cnt, 3'(j)}] <= rom_q[3'(7 - j)];
            fg[{ld_cnt, 3'(j)}]  <= rom_q[3'(7 - j)];
          end
          rom_a    <= ld_cnt + ROM_AW'(2);
          ld_cnt   <= ld_cnt + ROM_AW'(1);
          seek_idx <= '0;
        end
        S_SEEK: begin
          idx   <= '0;
          fwd   <= 1'b1;
          added <= 1'b0;
          if (img[seek_idx]) begin
            region[seek_idx] <= 1'b1;
            label            <= label + LABEL_W'(1);
          end else if (seek_idx != '1) begin
            seek_idx <= seek_idx + SRAM_AW'(1);
          end
        end
        S_GROW: begin
          if (grow_add) region[idx] <= 1'b1;
          // At a sweep end the pointer stays put and the direction reverses.
          if (sweep_end) begin
            if (added || grow_add) begin
              fwd   <= !fwd;
              added <= 1'b0;
            end else begin
              idx <= '0;
            end
          end else begin
            idx <= fwd ? idx + SRAM_AW'(1) : idx - SRAM_AW'(1);
            if (grow_add) added <= 1'b1;
          end
        end
        S_WRITE: begin
          if (region[idx]) begin
            sram_wen <= 1'b0;
            sram_a   <= idx;
            sram_d   <= label;
            img[idx] <= 1'b0;
          end
          idx <= idx + SRAM_AW'(1);
          if (idx_last) region <= '0;
        end
        S_CLEAR: begin
          if (!fg[idx]) begin
            sram_wen <= 1'b0;
            sram_a   <= idx;
            sram_d   <= '0;
          end
          idx <= idx + SRAM_AW'(1);
        end
        S_DONE: finish <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cle_engine.sv
// Scoreboard bench for cle_engine with behavioural ROM/SRAM and a flood-fill reference model.
module tb_cle_engine;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rom_q;
  logic [6:0] rom_a;
  logic [9:0] sram_a;
  logic [7:0] sram_d;
  logic       sram_wen;
  logic       finish;

  always #5 clk = ~clk;

  cle_engine dut (
    .clk      (clk),
    .reset    (reset),
    .rom_q    (rom_q),
    .rom_a    (rom_a),
    .sram_a   (sram_a),
    .sram_d   (sram_d),
    .sram_wen (sram_wen),
    .finish   (finish)
  );

  logic [7:0] rom  [128];
  logic [7:0] sram [1024];
  int         wcnt [1024];

  always @(posedge clk) rom_q <= rom[rom_a];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 1024; i++) begin
        sram[i] <= 8'hEE;
        wcnt[i] <= 0;
      end
    end else if (!sram_wen) begin
      sram[sram_a] <= sram_d;
      wcnt[sram_a] <= wcnt[sram_a] + 1;
    end
  end

  int         total = 0;
  int         bad = 0;
  int         clean_cyc = 0;
  logic [7:0] exp_q [$];

  // Reference labels: stack-based flood fill started from each unlabelled pixel in raster order.
  task automatic model_push(input logic [1023:0] pic);
    int lab [1024];
    int st [$];
    int n, q, r, c, nr, nc, np;
    n = 0;
    for (int p = 0; p < 1024; p++) lab[p] = 0;
    for (int p = 0; p < 1024; p++) begin
      if (pic[p] && lab[p] == 0) begin
        n++;
        lab[p] = n;
        st.push_back(p);
        while (st.size() > 0) begin
          q = st.pop_back();
          r = q / 32;
          c = q % 32;
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              nr = r + dr;
              nc = c + dc;
              if ((dr != 0 || dc != 0) && nr >= 0 && nr < 32 && nc >= 0 && nc < 32) begin
                np = nr * 32 + nc;
                if (pic[np] && lab[np] == 0) begin
                  lab[np] = n;
                  st.push_back(np);
                end
              end
            end
          end
        end
      end
    end
    for (int p = 0; p < 1024; p++) exp_q.push_back(8'(lab[p]));
  endtask

  task automatic set_image(input logic [1023:0] pic);
    for (int b = 0; b < 128; b++)
      for (int j = 0; j < 8; j++)
        rom[b][7-j] = pic[b*8+j];
    model_push(pic);
  endtask

  task automatic release_and_wait(input string name, output int cyc);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    while (finish !== 1'b1 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (finish !== 1'b1) begin
      bad++;
      $display("FAIL %s finish: got %b after %0d cycles, required 1", name, finish, cyc);
    end
  endtask

  task automatic run_image(input string name, output int cyc);
    @(negedge clk);
    reset = 1'b0;
    release_and_wait(name, cyc);
  endtask

  task automatic check_sram(input string name);
    int         mism, first, wbad, wfirst;
    logic [7:0] e, first_got, first_exp;
    mism = 0; first = -1; wbad = 0; wfirst = -1;
    first_got = '0; first_exp = '0;
    for (int p = 0; p < 1024; p++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
      if (sram[p] !== e) begin
        if (mism == 0) begin first = p; first_got = sram[p]; first_exp = e; end
        mism++;
      end
      if (wcnt[p] != 1) begin
        if (wbad == 0) wfirst = p;
        wbad++;
      end
    end
    total++;
    if (mism !== 0) begin
      bad++;
      $display("FAIL %s sram: %0d wrong words, first addr %0d got %02h required %02h",
               name, mism, first, first_got, first_exp);
    end
    total++;
    if (wbad !== 0) begin
      bad++;
      $display("FAIL %s writes: %0d addresses not written once, first addr %0d count %0d required 1",
               name, wbad, wfirst, (wfirst >= 0) ? wcnt[wfirst] : 0);
    end
    repeat (20) @(negedge clk);
    total++;
    if (finish !== 1'b1) begin
      bad++;
      $display("FAIL %s finish_hold: got %b required 1", name, finish);
    end
  endtask

  task automatic test_reset;
    #3 reset = 1'b0;
    #1;
    total++; if (finish !== 1'b0)   begin bad++; $display("FAIL rst finish: got %b required 0", finish); end
    total++; if (sram_wen !== 1'b1) begin bad++; $display("FAIL rst sram_wen: got %b required 1", sram_wen); end
    total++; if (rom_a !== 7'd0)    begin bad++; $display("FAIL rst rom_a: got %0d required 0", rom_a); end
    total++; if (sram_a !== 10'd0)  begin bad++; $display("FAIL rst sram_a: got %0d required 0", sram_a); end
    total++; if (sram_d !== 8'd0)   begin bad++; $display("FAIL rst sram_d: got %02h required 00", sram_d); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++; if (rom_a !== 7'd1) begin bad++; $display("FAIL leave_idle rom_a: got %0d required 1", rom_a); end
  endtask

  task automatic test_all_zero;
    int cyc;
    set_image('0);
    run_image("zero", cyc);
    check_sram("zero");
  endtask

  task automatic test_all_one;
    int cyc;
    set_image('1);
    run_image("ones", cyc);
    check_sram("ones");
  endtask

  task automatic test_corners;
    logic [1023:0] pic;
    int cyc;
    pic = '0;
    pic[0] = 1'b1;
    pic[1023] = 1'b1;
    set_image(pic);
    run_image("corners", cyc);
    total++; if (sram[0] !== 8'h01)    begin bad++; $display("FAIL corners first: got %02h required 01", sram[0]); end
    total++; if (sram[1023] !== 8'h02) begin bad++; $display("FAIL corners last: got %02h required 02", sram[1023]); end
    check_sram("corners");
  endtask

  task automatic test_diagonal;
    logic [1023:0] pic;
    int cyc, ok;
    pic = '0;
    for (int r = 0; r < 32; r++) pic[r*33] = 1'b1;
    set_image(pic);
    run_image("diag", cyc);
    clean_cyc = cyc;
    ok = 0;
    for (int r = 0; r < 32; r++) if (sram[r*33] === 8'h01) ok++;
    total++; if (ok !== 32) begin bad++; $display("FAIL diag labels: %0d pixels labelled 01, required 32", ok); end
    check_sram("diag");
  endtask

  task automatic test_blobs;
    logic [1023:0] pic;
    logic [255:0]  seen;
    int cyc, nlab;
    int br [5] = '{2, 2, 2, 10, 10};
    int bc [5] = '{2, 10, 20, 2, 26};
    pic = '0;
    for (int k = 0; k < 5; k++)
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++)
          pic[(br[k]+dr)*32 + bc[k] + dc] = 1'b1;
    for (int r = 12; r <= 20; r++) begin
      pic[r*32+10] = 1'b1;
      pic[r*32+16] = 1'b1;
    end
    for (int c = 10; c <= 16; c++) pic[20*32+c] = 1'b1;
    set_image(pic);
    run_image("blobs", cyc);
    total++;
    if (sram[12*32+10] !== sram[12*32+16] || sram[12*32+10] === 8'h00) begin
      bad++;
      $display("FAIL u_shape: left arm %02h right arm %02h, required equal nonzero",
               sram[12*32+10], sram[12*32+16]);
    end
    seen = '0;
    for (int p = 0; p < 1024; p++) if (sram[p] !== 8'h00) seen[sram[p]] = 1'b1;
    nlab = $countones(seen);
    total++; if (nlab !== 6) begin bad++; $display("FAIL blobs distinct: got %0d labels required 6", nlab); end
    check_sram("blobs");
  endtask

  task automatic test_reset_in_grow;
    logic [1023:0] pic;
    int cyc;
    pic = '0;
    for (int r = 0; r < 32; r++) pic[r*33] = 1'b1;
    set_image(pic);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (600) @(negedge clk);
    total++; if (finish !== 1'b0) begin bad++; $display("FAIL grow_abort finish: got %b required 0", finish); end
    #1 reset = 1'b0;
    #1;
    total++; if (rom_a !== 7'd0)    begin bad++; $display("FAIL async rom_a: got %0d required 0", rom_a); end
    total++; if (sram_wen !== 1'b1) begin bad++; $display("FAIL async sram_wen: got %b required 1", sram_wen); end
    @(negedge clk);
    release_and_wait("rerun", cyc);
    total++;
    if (cyc !== clean_cyc) begin
      bad++;
      $display("FAIL rerun cycles: got %0d required %0d", cyc, clean_cyc);
    end
    check_sram("rerun");
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_all_one();
    test_corners();
    test_diagonal();
    test_blobs();
    test_reset_in_grow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
